// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch counters: BCD digit limit and the
// run/pause state encoding.
package stopwatch_pkg;

  localparam logic [3:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2,
    DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/bcd_digit.sv
// One BCD decade: counts 0..9 when enabled and produces a combinational
// carry into the next decade on the 9 -> 0 step.
module bcd_digit
  import stopwatch_pkg::*;
(
  input  logic       clk,
  input  logic       r,
  input  logic       clr,
  input  logic       en,
  output logic [3:0] q,
  output logic       carry
);

  assign carry = en && (q == BCD_MAX);

  // NOTE: clocked state is written only with non-blocking assignments so every
  // decade samples its neighbours' pre-edge values, regardless of block order.
  always_ff @(posedge clk) begin
    if (r || clr) begin
      q <= 4'd0;
    end else if (en) begin
      q <= (q == BCD_MAX) ? 4'd0 : q + 4'd1;
    end
  end

endmodule

// File: rtl/up_counter.sv
// BCD up-counting stopwatch core: run/pause FSM gating a chain of BCD
// decades, saturating at all-nines (WRAP=0) or rolling over (WRAP=1).
module up_counter
  import stopwatch_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter bit WRAP       = 1'b0
) (
  input  logic                    clk,
  input  logic                    r,
  input  logic                    tick,
  input  logic                    s,
  input  logic                    clr,
  output logic [4*NUM_DIGITS-1:0] count,
  output logic                    running,
  output logic                    done
);

  state_t                state;
  logic                  all_nines;
  logic                  run_tick;
  logic                  saturate;
  logic [NUM_DIGITS:0]   chain;
  logic                  carry_unused;

  always_comb begin
    all_nines = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (count[4*i +: 4] != BCD_MAX) all_nines = 1'b0;
    end
  end

  assign run_tick = tick && (state == RUNNING);
  // Without wrap, the terminal tick must not reach the decades: the count holds at all-nines.
  assign saturate = !WRAP && run_tick && all_nines;
  assign chain[0] = run_tick && !saturate;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    bcd_digit u_digit (
      .clk   (clk),
      .r     (r),
      .clr   (clr),
      .en    (chain[i]),
      .q     (count[4*i +: 4]),
      .carry (chain[i+1])
    );
  end

  // The carry out of the top decade has no consumer; rollover is implicit.
  assign carry_unused = chain[NUM_DIGITS];

  // NOTE: reset here is synchronous, so it lives inside the clocked branch
  // rather than in the sensitivity list.
  always_ff @(posedge clk) begin
    if (r || clr) begin
      state   <= IDLE;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (s) begin
            state   <= RUNNING;
            running <= 1'b1;
          end
        end
        RUNNING: begin
          if (saturate) begin
            state   <= DONE;
            running <= 1'b0;
            done    <= 1'b1;
          end else if (s) begin
            state   <= PAUSED;
            running <= 1'b0;
          end
        end
        PAUSED: begin
          if (s) begin
            state   <= RUNNING;
            running <= 1'b1;
          end
        end
        default: begin
          state <= DONE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_up_counter.sv
// Scoreboard bench for up_counter: a saturating and a wrapping instance share
// stimulus; the driver queues expected results, a monitor pops and compares.
module tb_up_counter;

  logic        clk = 1'b0;
  logic        r   = 1'b1;
  logic        s   = 1'b0;
  logic        tick = 1'b0;
  logic        clr = 1'b0;
  logic [15:0] count_sat, count_wrap;
  logic        running_sat, running_wrap;
  logic        done_sat, done_wrap;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    string       name;
    bit          chk;
    logic [15:0] c0;
    bit          r0;
    bit          d0;
    logic [15:0] c1;
    bit          r1;
    bit          d1;
  } item_t;

  item_t sb[$];

  always #5 clk = ~clk;

  up_counter #(.NUM_DIGITS(4), .WRAP(1'b0)) u_sat (
    .clk(clk), .r(r), .tick(tick), .s(s), .clr(clr),
    .count(count_sat), .running(running_sat), .done(done_sat)
  );

  up_counter #(.NUM_DIGITS(4), .WRAP(1'b1)) u_wrap (
    .clk(clk), .r(r), .tick(tick), .s(s), .clr(clr),
    .count(count_wrap), .running(running_wrap), .done(done_wrap)
  );

  task automatic check(input string name, input logic [17:0] actual, input logic [17:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("FAIL %s: got count=%h running=%b done=%b, expected count=%h running=%b done=%b",
               name, actual[17:2], actual[1], actual[0], expected[17:2], expected[1], expected[0]);
    end
  endtask

  // Monitor: outputs are presented every cycle; sample 1 time unit after the edge.
  initial begin
    item_t it;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        it = sb.pop_front();
        if (it.chk) begin
          check({it.name, "/sat"},  {count_sat, running_sat, done_sat},    {it.c0, it.r0, it.d0});
          check({it.name, "/wrap"}, {count_wrap, running_wrap, done_wrap}, {it.c1, it.r1, it.d1});
        end
      end
    end
  end

  task automatic step(input bit r_i, input bit s_i, input bit t_i, input bit c_i,
                      input bit chk, input string nm,
                      input logic [15:0] c0, input bit r0, input bit d0,
                      input logic [15:0] c1, input bit r1, input bit d1);
    item_t it;
    @(negedge clk);
    r = r_i; s = s_i; tick = t_i; clr = c_i;
    it.name = nm; it.chk = chk;
    it.c0 = c0; it.r0 = r0; it.d0 = d0;
    it.c1 = c1; it.r1 = r1; it.d1 = d1;
    sb.push_back(it);
  endtask

  task automatic same(input bit r_i, input bit s_i, input bit t_i, input bit c_i,
                      input string nm, input logic [15:0] c, input bit run, input bit dn);
    step(r_i, s_i, t_i, c_i, 1'b1, nm, c, run, dn, c, run, dn);
  endtask

  // n back-to-back ticks; only the result after the last one is checked.
  task automatic ticks(input int n, input string nm, input logic [15:0] c, input bit run);
    for (int i = 0; i < n - 1; i++)
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, nm, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    same(1'b0, 1'b0, 1'b1, 1'b0, nm, c, run, 1'b0);
  endtask

  initial begin
    // Reset held two cycles
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "reset0", 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    same(1'b1, 1'b0, 1'b0, 1'b0, "reset", 16'h0000, 1'b0, 1'b0);
    ticks(5, "idle_ticks", 16'h0000, 1'b0);

    // Start with a simultaneous tick: the tick is ignored in IDLE
    same(1'b0, 1'b1, 1'b1, 1'b0, "start", 16'h0000, 1'b1, 1'b0);
    ticks(12, "count12", 16'h0012, 1'b1);
    same(1'b0, 1'b1, 1'b1, 1'b0, "pause_with_tick", 16'h0013, 1'b0, 1'b0);
    ticks(3, "paused_ticks", 16'h0013, 1'b0);
    same(1'b0, 1'b1, 1'b1, 1'b0, "resume_tick_dropped", 16'h0013, 1'b1, 1'b0);
    ticks(1, "count14", 16'h0014, 1'b1);

    // Priority: clr beats s and tick
    ticks(28, "count42", 16'h0042, 1'b1);
    same(1'b0, 1'b1, 1'b1, 1'b1, "clr_priority", 16'h0000, 1'b0, 1'b0);

    // Reset mid-count
    same(1'b0, 1'b1, 1'b0, 1'b0, "start2", 16'h0000, 1'b1, 1'b0);
    ticks(123, "count123", 16'h0123, 1'b1);
    same(1'b1, 1'b1, 1'b1, 1'b1, "r_midcount", 16'h0000, 1'b0, 1'b0);
    ticks(1, "idle_after_r", 16'h0000, 1'b0);

    // Carry ripple through the chain
    same(1'b0, 1'b1, 1'b0, 1'b0, "start3", 16'h0000, 1'b1, 1'b0);
    ticks(99, "count99", 16'h0099, 1'b1);
    ticks(1, "carry_0100", 16'h0100, 1'b1);
    ticks(899, "count999", 16'h0999, 1'b1);
    ticks(1, "carry_1000", 16'h1000, 1'b1);
    ticks(8999, "count9999", 16'h9999, 1'b1);

    // Terminal tick: saturate/DONE vs rollover
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, "terminal", 16'h9999, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, "post_terminal", 16'h9999, 1'b0, 1'b1, 16'h0001, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "s_after_terminal", 16'h9999, 1'b0, 1'b1, 16'h0001, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, "tick_held", 16'h9999, 1'b0, 1'b1, 16'h0001, 1'b0, 1'b0);
    same(1'b0, 1'b0, 1'b0, 1'b1, "clr_from_done", 16'h0000, 1'b0, 1'b0);

    // Terminal tick coinciding with s
    same(1'b0, 1'b1, 1'b0, 1'b0, "start4", 16'h0000, 1'b1, 1'b0);
    ticks(9999, "count9999_b", 16'h9999, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, "terminal_with_s", 16'h9999, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, "after_terminal_s", 16'h9999, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "s_again", 16'h9999, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
    same(1'b1, 1'b0, 1'b0, 1'b0, "final_reset", 16'h0000, 1'b0, 1'b0);

    @(negedge clk);
    r = 1'b0; s = 1'b0; tick = 1'b0; clr = 1'b0;
    @(posedge clk);
    #2;
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/up_counter.md
# up_counter

BCD up-counting stopwatch core that counts elapsed time upward from zero, the complement to the modulo-10 down-counter used in the countdown mode. It accepts a rate tick from the clock divider plus start/stop and clear controls, and produces a packed multi-digit BCD value for the display multiplexer. A small run/pause state machine gates counting. The count either saturates at all-nines or wraps, selected by parameter.

## Interface
- `NUM_DIGITS`, default 4: number of BCD decades in the count.
- `WRAP`, default 0:
  - 0: saturate at all-nines and enter DONE.
  - 1: roll over to zero and keep running.
- `clk` in 1: system clock, rising-edge.
- `r` in 1: reset, synchronous, active-high.
- `tick` in 1: single-cycle count-enable pulse from the clock divider, e.g. 100 Hz.
- `s` in 1: start/stop request, single-cycle pulse, debounced externally.
- `clr` in 1: clear request, single-cycle pulse.
- `count` out 4*NUM_DIGITS: packed BCD count. Digit 0 (least significant) is `[3:0]`.
- `running` out 1: high while in RUNNING.
- `done` out 1: high while in DONE (only reachable with WRAP=0).

## Operation
- States:
  - IDLE: count all-zero.
  - RUNNING: count advances on tick.
  - PAUSED: count held.
  - DONE: count held at all-nines.
- Control priority at each rising edge: `r` > `clr` > `s` > `tick`.
- `r` or `clr`:
  - From any state, next state is IDLE and count is zero.
  - Any `s` or `tick` in the same cycle is discarded.
- IDLE:
  - `s` → RUNNING.
  - `tick` is ignored.
- RUNNING:
  - `tick` increments the count by one.
  - `s` → PAUSED.
  - If `s` and `tick` arrive in the same cycle, the tick is counted and the state moves to PAUSED on that edge.
- PAUSED:
  - `s` → RUNNING.
  - `tick` is ignored, including a tick in the same cycle as `s`. That tick is not counted.
- DONE:
  - `s` and `tick` are ignored.
  - Only `clr` or `r` exits.
- Increment arithmetic:
  - Each digit counts 0..9.
  - A digit carries into the next when it is 9 and its enable is high. It then becomes 0.
  - The whole carry chain resolves in one cycle. Example: 0999 → 1000 on a single tick edge.
- Terminal condition: RUNNING with `tick` while every digit is 9.
  - WRAP=0: count stays all-nines and state → DONE. If `s` arrives in the same cycle, DONE takes precedence.
  - WRAP=1: count → all-zero and state remains RUNNING. If `s` arrives in the same cycle, state → PAUSED with count zero.
- Digits never hold values 10–15. The design needs no recovery path for them.

## Timing
- All outputs are registered.
- Reset values: `count` = 0, `running` = 0, `done` = 0, state IDLE.
- Latency: `tick` sampled at edge N → updated `count` is visible after edge N. This is one cycle of latency with no further pipelining.
- `running` and `done` change on the same edge as the state transition.
- `s` held high for k cycles counts as k toggles. Conditioning `s` to a single-cycle pulse is the upstream's responsibility.
- Back-to-back ticks on consecutive cycles are supported, one increment per cycle.

## Structure
- Shared package (`stopwatch_pkg`) holds:
  - `BCD_MAX` = 4'd9.
  - The state encoding: IDLE=2'd0, RUNNING=2'd1, PAUSED=2'd2, DONE=2'd3.
- Sub-module `bcd_digit`: one decade.
  - Inputs: `clk`, `r`, `clr`, `en`.
  - Outputs: `q[3:0]`, `carry` (combinational `en && q==9`).
  - Instantiated NUM_DIGITS times in a generate loop, each `en` chained from the previous `carry`.
  - Digit 0 `en` = `tick` qualified by RUNNING and not terminal-saturating.
- The top module holds the FSM and the all-nines detect.

## Test plan
- Reset check: assert `r` for 2 cycles → `count`=0000, `running`=0, `done`=0. Then 5 ticks in IDLE → `count` stays 0000.
- Counting and pause: `s`, 12 ticks → `count`=0012, `running`=1. Then `s` together with a tick → 0013 and PAUSED. Then 3 ticks → still 0013. Then `s` and 1 tick → 0014.
- Carry ripple: run to 0099, one tick → 0100 on the next edge. Run to 0999, one tick → 1000.
- Saturation (WRAP=0): run to 9999 → `done`=1, `running`=0. Further ticks and `s` → `count` stays 9999. Then `clr` → 0000, IDLE.
- Wrap (WRAP=1): at 9999, one tick → 0000 with `running`=1. The next tick → 0001.
- Priority: `clr`, `s` and `tick` asserted together while RUNNING at 0042 → 0000 and IDLE. `r` asserted mid-count at 0123 → 0000, IDLE on the next edge.
